rv_dffe: RTL and testbench
==========================

# rv_dffe

Library block that provides a clock-gated, enable-controlled register bank for wide datapath state. Examples are address and data capture registers in bus bridges. It contains two sub-blocks: a latch-based clock-gating header (`rvclkhdr`) and a plain asynchronous-reset flop array (`rvdff`). It composes them into the enable flop (`rvdffe`). The register is clocked by a gated local clock, so it saves power whenever the enable is low.

## Interface
- WIDTH, default 32: register width in bits. It must be ≥ 8. A smaller value is an elaboration-time error; narrow state uses `rvdff` or a mux-based enable flop.
- clk  input  1  free-running core clock.
- rst_l  input  1  reset, asynchronous and active-low.
- en  input  1  load enable. When 1, din is captured at the next rising edge of clk.
- scan_mode  input  1  test enable. When 1, it forces the clock gate open regardless of en.
- din  input  WIDTH  data in.
- dout  output  WIDTH  registered data out.

## Operation
- Sub-block `rvclkhdr`:
  - Ports: clk, en, scan_mode (inputs); l1clk (output).
  - Gate enable is `en | scan_mode`.
  - The gate enable is captured by a latch that is transparent while clk is low and holds while clk is high.
  - l1clk = clk AND latched enable. This gives a glitch-free gated clock: an enable change while clk is high has no effect until the next low phase.
  - The header has no reset input.
- Sub-block `rvdff`:
  - Parameter WIDTH, default 1.
  - Ports: clk, rst_l, din, dout.
  - dout ← din on every rising clk edge.
  - dout is forced to all-zeros immediately when rst_l falls, and held at zero while rst_l = 0.
- Top `rv_dffe` (`rvdffe` behaviour):
  - clk, en and scan_mode drive one `rvclkhdr`.
  - Its l1clk clocks an `rvdff` of width WIDTH, with din/dout/rst_l connected straight through.
  - There is no data mux. Hold behaviour comes solely from clock gating.
- Reset value of dout is 0 (all WIDTH bits).
- Reset is independent of en and scan_mode: asserting rst_l = 0 mid-operation clears dout even if the gate is closed.
- While rst_l = 0, capture edges have no effect. After rst_l rises, the first capture occurs at the first rising clk edge with en = 1.

## Timing
- Latency is one cycle: din sampled at rising edge N with en = 1 appears on dout right after edge N.
- en must be stable and valid before the rising edge. It is sampled during the preceding clk-low phase. en toggling while clk is high is ignored for the current edge.
- en = 0 means dout holds indefinitely and l1clk stays low.
- scan_mode = 1 means capture on every edge, whatever en is.
- en = 1 on consecutive cycles gives back-to-back captures every cycle with no bubble.
- Simultaneous en = 1 and reset assertion: reset wins, dout = 0.
- Reset deassertion coincident with a capture edge: capture is not guaranteed. The bench must deassert rst_l at least one clk-low phase before the first intended capture.

## Test plan
- Reset: WIDTH = 32, rst_l = 0 asynchronously mid-cycle with dout = 0xDEADBEEF -> dout = 0x00000000 immediately, with no clock edge required. dout stays 0 while en = 1 and rst_l = 0.
- Load/hold: en = 1 with din = 0x12345678 for one cycle, then en = 0 with din = 0xFFFFFFFF for 5 cycles -> dout = 0x12345678 throughout the 5 cycles, and l1clk has no pulses during hold.
- Back-to-back: en = 1 for 4 cycles with din = 1, 2, 3, 4 -> dout = 1, 2, 3, 4 on successive edges, each one cycle after it is presented.
- Glitch immunity: raise en during the clk-high phase, then drop it before clk falls -> no l1clk pulse and dout unchanged. Raise en during clk low -> capture at the next edge.
- Scan override: en = 0, scan_mode = 1, din = 0xA5A5A5A5 -> dout = 0xA5A5A5A5 after one edge. Then scan_mode = 0 -> dout holds.
- Elaboration: WIDTH = 4 -> elaboration error. WIDTH = 64 with din = 0x0123456789ABCDEF, en = 1 -> dout = 0x0123456789ABCDEF.

Source files
------------

// File: rtl/rv_dffe_if.sv
// Bus bundle for the clock-gated enable register: load controls and data in/out.
interface rv_dffe_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic             scan_mode;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;

   modport master (
      output en,
      output scan_mode,
      output din,
      input  dout
   );

   modport slave (
      input  en,
      input  scan_mode,
      input  din,
      output dout
   );
endinterface

// File: rtl/rv_dffe.sv
// Enable flop built from a latch-based clock gate feeding an async-reset flop array;
// hold comes purely from the gated clock, there is no feedback mux.
module rvclkhdr (
   input  logic clk,
   input  logic en,
   input  logic scan_mode,
   output logic l1clk
);
   logic gate_en;
   logic en_latched;

   assign gate_en = en | scan_mode;

   // Transparent only while clk is low, so enable changes in the high phase cannot glitch l1clk.
   always_latch begin
      if (!clk) en_latched = gate_en;
   end

   assign l1clk = clk & en_latched;
endmodule

module rvdff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = din;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) data_q <= '0;
      else        data_q <= data_d;
   end

   assign dout = data_q;
endmodule

module rv_dffe #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_l,
   rv_dffe_if.slave    bus
);
   // Narrow state is cheaper as a plain flop or mux-enable flop than behind a clock gate.
   generate
      if (WIDTH < 8) begin : g_width_check
         $error("rv_dffe: WIDTH must be >= 8");
      end
   endgenerate

   logic l1clk;

   rvclkhdr u_hdr (
      .clk       (clk),
      .en        (bus.en),
      .scan_mode (bus.scan_mode),
      .l1clk     (l1clk)
   );

   rvdff #(.WIDTH(WIDTH)) u_dff (
      .clk   (l1clk),
      .rst_l (rst_l),
      .din   (bus.din),
      .dout  (bus.dout)
   );
endmodule

// File: tb/tb_rv_dffe.sv
// Directed bench for rv_dffe at WIDTH 32 and 64: reset, load/hold, back-to-back, glitch, scan.
module tb_rv_dffe;
   logic clk;
   logic rst_l;
   int   checks;
   int   errors;
   int   l1_pulses;
   int   pulse_snap;

   rv_dffe_if #(.WIDTH(32)) bus32 ();
   rv_dffe_if #(.WIDTH(64)) bus64 ();

   rv_dffe #(.WIDTH(32)) dut32 (.clk(clk), .rst_l(rst_l), .bus(bus32.slave));
   rv_dffe #(.WIDTH(64)) dut64 (.clk(clk), .rst_l(rst_l), .bus(bus64.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial l1_pulses = 0;
   always @(posedge dut32.l1clk) l1_pulses = l1_pulses + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_l = 1'b0;
      bus32.en = 1'b0; bus32.scan_mode = 1'b0; bus32.din = '0;
      bus64.en = 1'b0; bus64.scan_mode = 1'b0; bus64.din = '0;

      repeat (3) @(negedge clk);
      check("reset32", {32'h0, bus32.dout}, 64'h0);
      check("reset64", bus64.dout, 64'h0);

      // Load a known pattern so the asynchronous clear is observable.
      rst_l = 1'b1;
      @(negedge clk);
      bus32.en = 1'b1; bus32.din = 32'hDEADBEEF;
      @(negedge clk);
      check("preload", {32'h0, bus32.dout}, 64'hDEADBEEF);
      bus32.en = 1'b0;

      @(posedge clk); #2;
      rst_l = 1'b0;
      #1;
      check("async_clr", {32'h0, bus32.dout}, 64'h0);
      bus32.en = 1'b1; bus32.din = 32'h11111111;
      repeat (2) @(negedge clk);
      check("rst_hold_en", {32'h0, bus32.dout}, 64'h0);
      rst_l = 1'b1;
      bus32.en = 1'b0;

      // Load then hold with en low and changing din.
      @(negedge clk);
      bus32.en = 1'b1; bus32.din = 32'h12345678;
      @(negedge clk);
      check("load", {32'h0, bus32.dout}, 64'h12345678);
      bus32.en = 1'b0; bus32.din = 32'hFFFFFFFF;
      pulse_snap = l1_pulses;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold", {32'h0, bus32.dout}, 64'h12345678);
      end
      check("hold_pulses", 64'(l1_pulses - pulse_snap), 64'h0);

      // Back-to-back captures.
      bus32.en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus32.din = 32'(i);
         @(posedge clk); #1;
         check("b2b", {32'h0, bus32.dout}, 64'(i));
         @(negedge clk);
      end
      bus32.en = 1'b0;

      // en pulse confined to the clk-high phase must not open the gate.
      bus32.din = 32'h00000077;
      pulse_snap = l1_pulses;
      @(posedge clk); #1;
      bus32.en = 1'b1;
      #2;
      bus32.en = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      check("glitch_dout", {32'h0, bus32.dout}, 64'h4);
      check("glitch_pulse", 64'(l1_pulses - pulse_snap), 64'h0);
      @(negedge clk);
      bus32.en = 1'b1;
      @(posedge clk); #1;
      check("low_en_cap", {32'h0, bus32.dout}, 64'h77);
      @(negedge clk);
      bus32.en = 1'b0;

      // Scan override.
      bus32.scan_mode = 1'b1; bus32.din = 32'hA5A5A5A5;
      @(posedge clk); #1;
      check("scan_cap", {32'h0, bus32.dout}, 64'hA5A5A5A5);
      @(negedge clk);
      bus32.scan_mode = 1'b0; bus32.din = 32'h0;
      repeat (3) @(negedge clk);
      check("scan_hold", {32'h0, bus32.dout}, 64'hA5A5A5A5);

      // Reset beats a simultaneous enable.
      bus32.en = 1'b1; bus32.din = 32'hCAFEF00D;
      rst_l = 1'b0;
      @(posedge clk); #1;
      check("rst_wins", {32'h0, bus32.dout}, 64'h0);
      @(negedge clk);
      rst_l = 1'b1; bus32.en = 1'b0;

      // Wide instance.
      @(negedge clk);
      bus64.en = 1'b1; bus64.din = 64'h0123456789ABCDEF;
      @(posedge clk); #1;
      check("w64_load", bus64.dout, 64'h0123456789ABCDEF);
      @(negedge clk);
      bus64.en = 1'b0; bus64.din = 64'hFFFFFFFFFFFFFFFF;
      repeat (2) @(negedge clk);
      check("w64_hold", bus64.dout, 64'h0123456789ABCDEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
